// File: rtl/gpu_fill_engine.sv
// Pixel-fill command engine: turns a latched fill command into constant-colour SDRAM write bursts.
// Optional macro GPU_FILL_CLIP_EN: out-of-frame origins complete immediately with no bursts.
module gpu_fill_engine #(
  parameter int H_RES  = 1024,
  parameter int V_RES  = 768,
  parameter int ADDR_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       x_pos,
  input  logic [15:0]       y_pos,
  input  logic [23:0]       pixel,
  input  logic [23:0]       len,
  input  logic              enable,
  input  logic [8:0]        sys_wr_len,
  output logic              busy,
  output logic              sys_vaild,
  output logic              burst_req,
  output logic [ADDR_W-1:0] burst_addr,
  output logic [8:0]        burst_len,
  input  logic              burst_ack,
  input  logic              wr_data_req,
  output logic [23:0]       wr_data
);

  localparam logic [ADDR_W:0] FRAME = (ADDR_W+1)'(H_RES * V_RES);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA, S_DONE} state_e;

  state_e            state_q;
  logic              en_q;
  logic [23:0]       col_q;
  logic [23:0]       rem_q;
  logic [8:0]        bsz_q;
  logic [8:0]        cnt_q;
  logic [ADDR_W-1:0] cur_q;
  logic              sys_vaild_q;
  logic              burst_req_q;
  logic [ADDR_W-1:0] burst_addr_q;
  logic [8:0]        burst_len_q;

  logic              start;
  logic              clip;
  logic [8:0]        bsz_d;
  logic [ADDR_W-1:0] org_addr;
  logic [ADDR_W-1:0] org_cur_d;
  logic [8:0]        start_len_d;
  logic              last_word;
  logic [ADDR_W:0]   adv_sum;
  logic [ADDR_W-1:0] cur_d;
  logic [23:0]       rem_d;
  logic [8:0]        next_len_d;

  // Burst length is bounded by remaining pixels, burst size and distance to frame end.
  function automatic logic [8:0] blen(input logic [23:0] r, input logic [8:0] b,
                                      input logic [ADDR_W-1:0] c);
    logic [31:0] m;
    logic [31:0] space;
    space = 32'(FRAME) - 32'(c);
    m     = 32'(b);
    if (32'(r) < m) m = 32'(r);
    if (space < m) m = space;
    return 9'(m);
  endfunction

  always_comb begin
    start       = enable && !en_q && (state_q == S_IDLE);
    bsz_d       = (sys_wr_len == 9'd0 || sys_wr_len > 9'd256) ? 9'd256 : sys_wr_len;
    org_addr    = ADDR_W'(48'(y_pos) * 48'(H_RES) + 48'(x_pos));
    org_cur_d   = ADDR_W'({1'b0, org_addr} % FRAME);
    start_len_d = blen(len, bsz_d, org_cur_d);
`ifdef GPU_FILL_CLIP_EN
    clip        = (32'(x_pos) >= 32'(H_RES)) || (32'(y_pos) >= 32'(V_RES));
`else
    clip        = 1'b0;
`endif
    last_word   = (state_q == S_DATA) && wr_data_req && ((cnt_q + 9'd1) == burst_len_q);
    adv_sum     = {1'b0, cur_q} + (ADDR_W+1)'(burst_len_q);
    cur_d       = (adv_sum == FRAME) ? '0 : adv_sum[ADDR_W-1:0];
    rem_d       = rem_q - 24'(burst_len_q);
    next_len_d  = blen(rem_d, bsz_q, cur_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      en_q         <= 1'b0;
      col_q        <= '0;
      rem_q        <= '0;
      bsz_q        <= '0;
      cnt_q        <= '0;
      cur_q        <= '0;
      sys_vaild_q  <= 1'b0;
      burst_req_q  <= 1'b0;
      burst_addr_q <= '0;
      burst_len_q  <= '0;
    end else begin
      en_q <= enable;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            col_q       <= pixel;
            rem_q       <= len;
            bsz_q       <= bsz_d;
            cur_q       <= org_cur_d;
            sys_vaild_q <= 1'b0;
            if (len == 24'd0 || clip) begin
              state_q <= S_DONE;
            end else begin
              state_q      <= S_REQ;
              burst_req_q  <= 1'b1;
              burst_addr_q <= org_cur_d;
              burst_len_q  <= start_len_d;
            end
          end
        end
        S_REQ: begin
          if (burst_ack) begin
            burst_req_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= S_DATA;
          end
        end
        S_DATA: begin
          if (wr_data_req) cnt_q <= cnt_q + 9'd1;
          // The next burst is issued directly from the post-burst address/remainder.
          if (last_word) begin
            cur_q <= cur_d;
            rem_q <= rem_d;
            if (rem_d == 24'd0) begin
              state_q <= S_DONE;
            end else begin
              state_q      <= S_REQ;
              burst_req_q  <= 1'b1;
              burst_addr_q <= cur_d;
              burst_len_q  <= next_len_d;
            end
          end
        end
        S_DONE: begin
          sys_vaild_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign sys_vaild  = sys_vaild_q;
  assign burst_req  = burst_req_q;
  assign burst_addr = burst_addr_q;
  assign burst_len  = burst_len_q;
  assign wr_data    = col_q;

endmodule

// File: tb/tb_gpu_fill_engine.sv
// Self-checking bench for gpu_fill_engine: directed and random fill commands against a burst-list model.
module tb_gpu_fill_engine;

  localparam int H = 1024;
  localparam int V = 768;
  localparam int F = H * V;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] x_pos = '0;
  logic [15:0] y_pos = '0;
  logic [23:0] pixel = '0;
  logic [23:0] len = '0;
  logic        enable = 1'b0;
  logic [8:0]  sys_wr_len = '0;
  logic        busy;
  logic        sys_vaild;
  logic        burst_req;
  logic [23:0] burst_addr;
  logic [8:0]  burst_len;
  logic        burst_ack = 1'b0;
  logic        wr_data_req = 1'b0;
  logic [23:0] wr_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned addr;
    int unsigned blen;
  } burst_t;
  burst_t exp_q[$];

  gpu_fill_engine #(.H_RES(H), .V_RES(V), .ADDR_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .x_pos(x_pos), .y_pos(y_pos), .pixel(pixel),
    .len(len), .enable(enable), .sys_wr_len(sys_wr_len), .busy(busy),
    .sys_vaild(sys_vaild), .burst_req(burst_req), .burst_addr(burst_addr),
    .burst_len(burst_len), .burst_ack(burst_ack), .wr_data_req(wr_data_req),
    .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected burst list derived directly from the fill rules.
  task automatic build_model(input int unsigned x, input int unsigned y,
                             input int unsigned n, input int unsigned swl);
    longint unsigned a;
    int unsigned cur, rem, bsz, l;
    burst_t b;
    exp_q.delete();
    a   = (longint'(y) * H + x) % (64'd1 << 24) % F;
    cur = int'(a);
    rem = n;
    bsz = (swl == 0 || swl > 256) ? 256 : swl;
`ifdef GPU_FILL_CLIP_EN
    if (x >= H || y >= V) rem = 0;
`endif
    while (rem > 0) begin
      l = rem;
      if (bsz < l) l = bsz;
      if (F - cur < l) l = F - cur;
      b.addr = cur;
      b.blen = l;
      exp_q.push_back(b);
      cur = (cur + l) % F;
      rem = rem - l;
    end
  endtask

  task automatic run_cmd(input int unsigned x, input int unsigned y, input logic [23:0] pix,
                         input int unsigned n, input int unsigned swl,
                         input int ack_dly, input bit retrig);
    int d;
    enable = 1'b0;
    tick();
    x_pos = 16'(x); y_pos = 16'(y); pixel = pix; len = 24'(n); sys_wr_len = 9'(swl);
    enable = 1'b1;
    build_model(x, y, n, swl);
    tick();
    x_pos = 16'($urandom); y_pos = 16'($urandom); pixel = 24'($urandom);
    len = 24'($urandom); sys_wr_len = 9'($urandom);
    enable = 1'($urandom_range(0, 1));
    chk("start_busy", 32'(busy), 1);
    chk("start_vaild_clr", 32'(sys_vaild), 0);
    chk("start_req", 32'(burst_req), (exp_q.size() != 0) ? 1 : 0);
    if (exp_q.size() == 0) begin
      chk("nob_wr_data", 32'(wr_data), 32'(pix));
      tick();
      chk("nob_busy_end", 32'(busy), 0);
      chk("nob_vaild", 32'(sys_vaild), 1);
      tick();
      chk("nob_idle", 32'(busy) + 32'(burst_req), 0);
      return;
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      chk("burst_addr", 32'(burst_addr), exp_q[i].addr);
      chk("burst_len", 32'(burst_len), exp_q[i].blen);
      d = (ack_dly >= 0) ? ack_dly : $urandom_range(0, 3);
      for (int k = 0; k < d; k++) begin
        wr_data_req = 1'($urandom_range(0, 1));
        tick();
        wr_data_req = 1'b0;
        chk("hold_req", 32'(burst_req), 1);
        chk("hold_addr", 32'(burst_addr), exp_q[i].addr);
        chk("hold_len", 32'(burst_len), exp_q[i].blen);
      end
      burst_ack = 1'b1;
      tick();
      burst_ack = 1'b0;
      chk("ack_req_low", 32'(burst_req), 0);
      for (int unsigned w = 0; w < exp_q[i].blen; w++) begin
        if (retrig) enable = w[0];
        if ($urandom_range(0, 1) == 1) tick();
        wr_data_req = 1'b1;
        tick();
        wr_data_req = 1'b0;
        chk("wr_data", 32'(wr_data), 32'(pix));
        if (w + 1 < exp_q[i].blen) chk("mid_req", 32'(burst_req) + 32'(!busy), 0);
      end
      if (i + 1 < exp_q.size()) begin
        chk("next_req", 32'(burst_req), 1);
      end else begin
        chk("done_busy", 32'(busy), 1);
        chk("done_req", 32'(burst_req), 0);
        chk("done_vaild_pre", 32'(sys_vaild), 0);
        tick();
        chk("end_busy", 32'(busy), 0);
        chk("end_vaild", 32'(sys_vaild), 1);
        tick();
        chk("post_idle", 32'(busy) + 32'(burst_req), 0);
      end
    end
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_vaild", 32'(sys_vaild), 0);
    chk("rst_req", 32'(burst_req), 0);
    chk("rst_addr", 32'(burst_addr), 0);
    chk("rst_len", 32'(burst_len), 0);
    chk("rst_wdata", 32'(wr_data), 0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 0);

    run_cmd(10, 2, 24'hA1B2C3, 100, 64, 5, 1'b0);
    run_cmd(0, 0, 24'h123456, 300, 0, -1, 1'b0);
    run_cmd(1014, 767, 24'h00FF00, 30, 64, -1, 1'b0);
    run_cmd(5, 5, 24'hFFFFFF, 0, 16, -1, 1'b0);
    run_cmd(100, 200, 24'h0F0F0F, 600, 300, -1, 1'b1);
    run_cmd(1024, 0, 24'h777777, 20, 8, -1, 1'b0);
    run_cmd(40000, 60000, 24'h515151, 40, 511, -1, 1'b0);

    // Reset asserted in the middle of a data phase.
    enable = 1'b0;
    tick();
    x_pos = 16'd0; y_pos = 16'd0; pixel = 24'hDEAD01; len = 24'd50; sys_wr_len = 9'd16;
    enable = 1'b1;
    tick();
    burst_ack = 1'b1;
    tick();
    burst_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wr_data_req = 1'b1;
      tick();
    end
    wr_data_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_req", 32'(burst_req), 0);
    chk("mrst_addr", 32'(burst_addr), 0);
    chk("mrst_len", 32'(burst_len), 0);
    chk("mrst_wdata", 32'(wr_data), 0);
    chk("mrst_vaild", 32'(sys_vaild), 0);
    enable = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    run_cmd(3, 1, 24'hC0FFEE, 20, 7, -1, 1'b0);

    for (int r = 0; r < 15; r++) begin
      run_cmd($urandom_range(0, 1100), $urandom_range(0, 800), 24'($urandom),
              ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 400),
              $urandom_range(0, 511), -1, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
